// File: rtl/win_33_p.sv
// 3x3 sliding-window generator with zero padding for a D x D raster stream.
// A single shift chain of 2*D+3 pixels holds the two previous rows plus the current taps.
module win_33_p #(
  parameter int D          = 299,
  parameter int data_width = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [data_width-1:0]   pxl_in,
  output logic                    ready,
  output logic [9*data_width-1:0] win_out,
  output logic                    valid_out,
  output logic                    last_out
);

  localparam int L    = 2 * D + 2;
  localparam int NPIX = D * D;
  localparam int CW   = $clog2(NPIX);
  localparam int RW   = $clog2(D);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [data_width-1:0]   sr    [L];
  logic [data_width-1:0]   chain [L+1];
  logic [CW-1:0]           in_cnt;
  logic [RW-1:0]           ctr_row, ctr_col;
  logic                    accept, emit, shift_en, ctr_end;
  logic [8:0]              pad;
  logic [9*data_width-1:0] win_nxt;

  assign ready    = (state != DRAIN);
  assign accept   = valid_in && ready;
  assign emit     = (state == RUN && accept) || state == DRAIN;
  assign shift_en = accept || state == DRAIN;
  assign ctr_end  = (ctr_row == RW'(D - 1)) && (ctr_col == RW'(D - 1));

  always_ff @(posedge clk) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:
        if (accept && in_cnt == CW'(D)) state_nxt = RUN;
      RUN:
        if (accept && in_cnt == CW'(NPIX - 1)) state_nxt = DRAIN;
      DRAIN:
        if (ctr_end) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_cnt <= '0;
    end else if (state == DRAIN && ctr_end) begin
      in_cnt <= '0;
    end else if (accept) begin
      if (in_cnt == CW'(NPIX - 1)) in_cnt <= '0;
      else                         in_cnt <= in_cnt + CW'(1);
    end
  end

  // Centre-pixel coordinates of the window produced on the next emit
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctr_row <= '0;
      ctr_col <= '0;
    end else if (emit) begin
      if (ctr_col == RW'(D - 1)) begin
        ctr_col <= '0;
        ctr_row <= ctr_end ? '0 : ctr_row + RW'(1);
      end else begin
        ctr_col <= ctr_col + RW'(1);
      end
    end
  end

  // Drain pushes zeros; those slots only ever land on padded taps
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < L; i++) sr[i] <= '0;
    end else if (shift_en) begin
      sr[0] <= accept ? pxl_in : '0;
      for (int i = 1; i < L; i++) sr[i] <= sr[i-1];
    end
  end

  always_comb begin
    chain[0] = accept ? pxl_in : '0;
    for (int i = 1; i <= L; i++) chain[i] = sr[i-1];
  end

  always_comb begin
    pad = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        pad[3*i+j] = (i == 0 && ctr_row == '0)
                  || (i == 2 && ctr_row == RW'(D - 1))
                  || (j == 0 && ctr_col == '0)
                  || (j == 2 && ctr_col == RW'(D - 1));
      end
    end
  end

  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!pad[3*i+j])
          win_nxt[(3*i+j)*data_width +: data_width] =
            chain[(2-i)*D + (2-j)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      win_out   <= '0;
    end else begin
      valid_out <= emit;
      if (emit) begin
        win_out  <= win_nxt;
        last_out <= ctr_end;
      end
    end
  end

endmodule
